fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage (F) of the 5-stage MIPS pipeline. It owns the PC and drives the instruction-bus request/response handshake. It presents the fetched instruction to Decode, and produces i_valid/i_data_ok for the hazard unit, which derives iresp_stall = i_valid & ~i_data_ok and returns stall_f. It supports delay-slot-preserving branch redirects from D and a discarding flush (exception/eret) that drops any in-flight fetch.

Parameters:
RESET_PC, 32'hbfc0_0000, PC loaded on reset.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stall_f  in  1  from hazard unit; 1 = F must not advance
redirect_valid  in  1  one-cycle pulse from D: branch/jump resolved taken
redirect_pc  in  32  branch/jump target
flush_valid  in  1  one-cycle pulse: discard in-flight fetch, restart
flush_pc  in  32  restart address
ireq_valid  out  1  instruction bus request valid
ireq_addr  out  32  request address
iresp_addr_ok  in  1  request accepted this cycle
iresp_data_ok  in  1  response data valid this cycle
iresp_data  in  32  response data
i_valid  out  1  to hazard: fetch in progress or held (1 in every state except IDLE)
i_data_ok  out  1  to hazard: instr_f valid this cycle
instr_f  out  32  instruction to D
pc_f  out  32  PC of instr_f / current fetch

Behaviour:
- Reset (async, resetn=0): state=IDLE, pc_q=RESET_PC, all pending flags=0, buffer=0. Outputs ireq_valid=0, i_valid=0, i_data_ok=0, instr_f=0, pc_f=RESET_PC.
- States are IDLE, REQ, WAIT, DONE, DROP.
- IDLE: lasts one cycle after reset, then goes to REQ.
- REQ: ireq_valid=1, ireq_addr=pc_q.
  - ireq_addr is held stable until iresp_addr_ok. A request is never withdrawn.
  - addr_ok & ~data_ok -> WAIT.
  - addr_ok & data_ok is legal and is treated as WAIT's data_ok case in the same cycle.
- WAIT, data_ok arrives (no drop pending): i_data_ok=1, instr_f=iresp_data.
  - stall_f=0: pc_q<=next_pc, go to REQ. Best case is one instruction per cycle with zero-wait addr_ok+data_ok.
  - stall_f=1: capture into buffer, go to DONE.
- DONE: i_data_ok=1, instr_f=buffer.
  - stall_f=0: pc_q<=next_pc, go to REQ.
  - stall_f=1: stay.
- DROP: ireq_valid=0, i_data_ok=0. When data_ok arrives, discard the data, pc_q<=flush target, go to REQ.
- next_pc and redirects:
  - next_pc = redirect target if a redirect is pending or arriving this cycle, else pc_q+4 (mod 2^32, wraps).
  - A redirect never discards the current fetch; that fetch is the delay slot.
  - The redirect pending flag is set on redirect_valid and cleared when next_pc is consumed. A same-cycle redirect is bypassed directly.
- flush_valid: takes priority over redirect; clears any pending redirect.
  - In REQ without addr_ok: set drop flag and hold the request. When addr_ok arrives, go to DROP, or discard immediately if data_ok arrives in the same cycle.
  - In REQ with addr_ok, or in WAIT: go to DROP. If data_ok arrives in the same cycle, discard, pc_q<=flush_pc, go to REQ.
  - In DONE: discard buffer, pc_q<=flush_pc, go to REQ.
  - In DROP: update flush target only.
  - While a drop is pending, i_data_ok=0.
- Combinational paths:
  - i_data_ok must not depend on stall_f, because stall_f depends combinationally on i_data_ok (loop avoidance).
  - ireq_valid depends on state only.
- pc_f = pc_q in all states.
- Reset mid-transaction: all state is lost. A late data_ok after reset is ignored in IDLE. The bus is reset on the same resetn.

Decomposition:
- Shared package:
  - fetch_state_t enum {IDLE, REQ, WAIT, DONE, DROP}
  - addr_t / word_t (32-bit)
  - PC_INC = 4
  - default RESET_PC constant
- One sub-module, fetch_pc_sel: combinational next_pc mux over flush target, redirect bypass/pending and pc_q+4.

Test Plan:
- Reset, then zero-wait bus (addr_ok=data_ok=1 every cycle) -> ireq_addr 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; i_data_ok=1 each cycle from the first REQ.
- addr_ok after 2 cycles, data_ok 3 cycles later -> ireq_addr held at 0xbfc00000 throughout; i_valid=1 & i_data_ok=0 until data_ok; instr_f = data 0x24020001.
- stall_f=1 for 3 cycles during data_ok -> DONE holds instr_f/pc_f stable; no new ireq until stall_f=0; next ireq_addr = pc+4.
- redirect_valid pc=0xbfc00100 while fetching 0xbfc00008 (delay slot) -> 0xbfc00008 delivered; next ireq_addr=0xbfc00100.
- flush_valid pc=0xbfc00380 in WAIT -> late response not delivered (i_data_ok=0); next ireq_addr=0xbfc00380.
- pc_q=0xfffffffc, no redirect -> next ireq_addr=0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam addr_t PC_INC           = 32'd4;
    localparam addr_t DEFAULT_RESET_PC = 32'hbfc0_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus request/response handshake between fetch and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  iresp_addr_ok;
    logic  iresp_data_ok;
    word_t iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_unit_pc_sel.sv
// Next-PC selection: restart target beats redirect, redirect beats sequential.
module fetch_pc_sel
    import fetch_unit_pkg::*;
(
    input  addr_t i_pc_q,
    input  logic  i_redirect_valid,
    input  addr_t i_redirect_pc,
    input  logic  i_redir_pend,
    input  addr_t i_redir_pc,
    input  logic  i_flush_valid,
    input  addr_t i_flush_pc,
    input  logic  i_drop_active,
    input  addr_t i_flush_pc_q,
    output addr_t o_next_pc
);

    // A same-cycle redirect bypasses the pending one (it is the newer target).
    always_comb begin
        if (i_flush_valid) begin
            o_next_pc = i_flush_pc;
        end else if (i_drop_active) begin
            o_next_pc = i_flush_pc_q;
        end else if (i_redirect_valid) begin
            o_next_pc = i_redirect_pc;
        end else if (i_redir_pend) begin
            o_next_pc = i_redir_pc;
        end else begin
            o_next_pc = i_pc_q + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs the instruction-bus handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         stall_f,
    input  logic         redirect_valid,
    input  addr_t        redirect_pc,
    input  logic         flush_valid,
    input  addr_t        flush_pc,
    fetch_unit_if.master ibus,
    output logic         i_valid,
    output logic         i_data_ok,
    output word_t        instr_f,
    output addr_t        pc_f
);

    localparam logic [2:0] S_IDLE = 3'(IDLE);
    localparam logic [2:0] S_REQ  = 3'(REQ);
    localparam logic [2:0] S_WAIT = 3'(WAIT);
    localparam logic [2:0] S_DONE = 3'(DONE);
    localparam logic [2:0] S_DROP = 3'(DROP);

    logic [2:0] r_state, w_state_nxt;
    addr_t      r_pc, w_pc_nxt;
    logic       r_redir_pend, w_redir_pend_nxt;
    addr_t      r_redir_pc, w_redir_pc_nxt;
    logic       r_drop, w_drop_nxt;
    addr_t      r_flush_pc, w_flush_pc_nxt;
    word_t      r_buf, w_buf_nxt;

    addr_t      w_next_pc;
    logic       w_addr_ok;
    logic       w_data_ok;
    logic       w_resp;
    logic       w_deliver;
    logic       w_drop_active;

    assign w_addr_ok     = ibus.iresp_addr_ok;
    assign w_data_ok     = ibus.iresp_data_ok;
    // Response belonging to the outstanding fetch (WAIT, or zero-wait in REQ).
    assign w_resp        = ((r_state == S_WAIT) | ((r_state == S_REQ) & w_addr_ok)) & w_data_ok;
    assign w_deliver     = w_resp & ~r_drop;
    assign w_drop_active = r_drop | (r_state == S_DROP);

    // Next-PC mux.
    fetch_pc_sel u_pc_sel (
        .i_pc_q           (r_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_redir_pend     (r_redir_pend),
        .i_redir_pc       (r_redir_pc),
        .i_flush_valid    (flush_valid),
        .i_flush_pc       (flush_pc),
        .i_drop_active    (w_drop_active),
        .i_flush_pc_q     (r_flush_pc),
        .o_next_pc        (w_next_pc)
    );

    // Next-state logic; a delivered-and-consumed fetch clears the pending redirect.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        w_drop_nxt       = r_drop;
        w_flush_pc_nxt   = r_flush_pc;
        w_buf_nxt        = r_buf;

        if (redirect_valid) begin
            w_redir_pend_nxt = 1'b1;
            w_redir_pc_nxt   = redirect_pc;
        end
        if (flush_valid) begin
            w_redir_pend_nxt = 1'b0;
            w_flush_pc_nxt   = flush_pc;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (flush_valid) begin
                    w_pc_nxt = w_next_pc;
                end
            end
            S_REQ: begin
                if (flush_valid || r_drop) begin
                    // Request stays up until accepted, then its data is thrown away.
                    if (w_addr_ok && w_data_ok) begin
                        w_pc_nxt   = w_next_pc;
                        w_drop_nxt = 1'b0;
                    end else if (w_addr_ok) begin
                        w_state_nxt = S_DROP;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (w_addr_ok) begin
                    if (w_data_ok) begin
                        if (stall_f) begin
                            w_buf_nxt   = ibus.iresp_data;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_pc_nxt         = w_next_pc;
                            w_redir_pend_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush_valid) begin
                    if (w_data_ok) begin
                        w_pc_nxt    = w_next_pc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else if (w_data_ok) begin
                    if (stall_f) begin
                        w_buf_nxt   = ibus.iresp_data;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pc_nxt         = w_next_pc;
                        w_redir_pend_nxt = 1'b0;
                        w_state_nxt      = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (flush_valid) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = S_REQ;
                end else if (!stall_f) begin
                    w_pc_nxt         = w_next_pc;
                    w_redir_pend_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
                end
            end
            S_DROP: begin
                if (w_data_ok) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_drop       <= 1'b0;
            r_flush_pc   <= '0;
            r_buf        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_flush_pc   <= w_flush_pc_nxt;
            r_buf        <= w_buf_nxt;
        end
    end

    // i_data_ok is kept free of stall_f because the hazard unit derives stall_f from it.
    assign ibus.ireq_valid = (r_state == S_REQ);
    assign ibus.ireq_addr  = r_pc;
    assign i_valid         = (r_state != S_IDLE);
    assign i_data_ok       = (r_state == S_DONE) | w_deliver;
    assign instr_f         = (r_state == S_DONE) ? r_buf : (w_deliver ? ibus.iresp_data : '0);
    assign pc_f            = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bus responder with programmable latency plus a transaction-level model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam addr_t RST_PC = 32'hbfc0_0000;

    logic  clk = 1'b0;
    logic  resetn;
    logic  stall_f;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  flush_valid;
    addr_t flush_pc;
    logic  i_valid;
    logic  i_data_ok;
    word_t instr_f;
    addr_t pc_f;

    fetch_unit_if ibus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_valid    (flush_valid),
        .flush_pc       (flush_pc),
        .ibus           (ibus),
        .i_valid        (i_valid),
        .i_data_ok      (i_data_ok),
        .instr_f        (instr_f),
        .pc_f           (pc_f)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // bus responder state
    bit    rand_lat;
    int    alat_fix;
    int    dlat_fix;
    bit    busy;
    bit    req_seen;
    int    acnt;
    int    dcnt;
    addr_t baddr;
    logic  drv_aok;
    logic  drv_dok;

    // reference model: instruction stream as seen by the program
    addr_t m_pc;     // PC of the instruction being fetched / held
    addr_t m_tgt;    // pending branch target
    addr_t m_ftgt;   // restart address after a discarded fetch
    bit    m_pend;
    bit    m_held;   // instruction returned but not yet taken by D
    bit    m_acc;    // address accepted, data still outstanding
    bit    m_drop;   // outstanding fetch will be discarded

    function automatic word_t mem(input addr_t a);
        if (a == 32'hbfc0_0000) return 32'h2402_0001;
        return a ^ 32'h5a5a_a5a5;
    endfunction

    function automatic int pick_lat(input int fixed);
        if (rand_lat) return int'($urandom_range(0, 3));
        return fixed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side of the handshake for the current cycle.
    task automatic bus_drive();
        int dl;
        drv_aok         = 1'b0;
        drv_dok         = 1'b0;
        ibus.iresp_data = '0;
        if (busy) begin
            if (dcnt == 0) begin
                drv_dok         = 1'b1;
                ibus.iresp_data = mem(baddr);
                busy            = 1'b0;
            end else begin
                dcnt--;
            end
        end else if (ibus.ireq_valid) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                acnt     = pick_lat(alat_fix);
            end
            if (acnt == 0) begin
                drv_aok  = 1'b1;
                req_seen = 1'b0;
                dl       = pick_lat(dlat_fix);
                if (dl == 0) begin
                    drv_dok         = 1'b1;
                    ibus.iresp_data = mem(ibus.ireq_addr);
                end else begin
                    busy  = 1'b1;
                    baddr = ibus.ireq_addr;
                    dcnt  = dl - 1;
                end
            end else begin
                acnt--;
            end
        end
        ibus.iresp_addr_ok = drv_aok;
        ibus.iresp_data_ok = drv_dok;
    endtask

    task automatic check_cycle();
        logic exp_idok;
        logic exp_rv;
        exp_idok = m_held || (drv_dok && !m_drop);
        exp_rv   = !m_acc && !m_held;
        chk("i_valid", 32'(i_valid), 32'd1);
        chk("ireq_valid", 32'(ibus.ireq_valid), 32'(exp_rv));
        if (exp_rv) chk("ireq_addr", ibus.ireq_addr, m_pc);
        chk("i_data_ok", 32'(i_data_ok), 32'(exp_idok));
        chk("pc_f", pc_f, m_pc);
        if (exp_idok) chk("instr_f", instr_f, mem(m_pc));
    endtask

    task automatic consume();
        m_pc   = m_pend ? m_tgt : m_pc + 32'd4;
        m_pend = 1'b0;
    endtask

    task automatic model_update(input logic s, input logic rv, input addr_t rp,
                                input logic fv, input addr_t fp);
        if (fv) begin
            m_pend = 1'b0;
            if (m_held) begin
                m_held = 1'b0;
                m_pc   = fp;
            end else if (drv_dok) begin
                m_pc   = fp;
                m_drop = 1'b0;
                m_acc  = 1'b0;
            end else begin
                m_drop = 1'b1;
                m_ftgt = fp;
                if (drv_aok) m_acc = 1'b1;
            end
        end else begin
            if (rv) begin
                m_pend = 1'b1;
                m_tgt  = rp;
            end
            if (drv_dok) begin
                m_acc = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_pc   = m_ftgt;
                end else if (s) begin
                    m_held = 1'b1;
                end else begin
                    consume();
                end
            end else begin
                if (m_held && !s) begin
                    m_held = 1'b0;
                    consume();
                end
                if (drv_aok) m_acc = 1'b1;
            end
        end
    endtask

    // One clock: inputs after the edge, bus response, settle, check, advance model.
    task automatic step(input logic s, input logic rv, input addr_t rp,
                        input logic fv, input addr_t fp);
        @(posedge clk);
        #1;
        stall_f        = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        flush_valid    = fv;
        flush_pc       = fp;
        bus_drive();
        #1;
        check_cycle();
        model_update(s, rv, rp, fv, fp);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Reset DUT and bus together, check reset outputs, release into IDLE.
    task automatic do_reset();
        resetn             = 1'b0;
        stall_f            = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        flush_valid        = 1'b0;
        flush_pc           = '0;
        ibus.iresp_addr_ok = 1'b0;
        ibus.iresp_data_ok = 1'b0;
        ibus.iresp_data    = '0;
        busy = 1'b0; req_seen = 1'b0; acnt = 0; dcnt = 0; baddr = '0;
        drv_aok = 1'b0; drv_dok = 1'b0;
        m_pc = RST_PC; m_tgt = '0; m_ftgt = '0;
        m_pend = 1'b0; m_held = 1'b0; m_acc = 1'b0; m_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", 32'(ibus.ireq_valid), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_i_data_ok", 32'(i_data_ok), 32'd0);
        chk("rst_instr_f", instr_f, 32'd0);
        chk("rst_pc_f", pc_f, RST_PC);
        resetn = 1'b1;
        #1;
        chk("idle_i_valid", 32'(i_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rand_lat = 1'b0;
        alat_fix = 0;
        dlat_fix = 0;

        // zero-wait bus: one instruction per cycle
        do_reset();
        nop();
        chk("zw_addr0", ibus.ireq_addr, 32'hbfc0_0000);
        chk("zw_dok0", 32'(i_data_ok), 32'd1);
        chk("zw_instr0", instr_f, 32'h2402_0001);
        nop();
        chk("zw_addr1", ibus.ireq_addr, 32'hbfc0_0004);
        chk("zw_dok1", 32'(i_data_ok), 32'd1);
        nop();
        chk("zw_addr2", ibus.ireq_addr, 32'hbfc0_0008);
        chk("zw_dok2", 32'(i_data_ok), 32'd1);

        // addr_ok after 2 waits, data_ok 3 cycles later (reset lands mid-stream)
        alat_fix = 2;
        dlat_fix = 3;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            nop();
            if (k < 3) chk("lat_addr_hold", ibus.ireq_addr, 32'hbfc0_0000);
            chk("lat_i_valid", 32'(i_valid), 32'd1);
            chk("lat_i_data_ok", 32'(i_data_ok), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("lat_instr", instr_f, 32'h2402_0001);

        // stall during data_ok holds the instruction
        alat_fix = 0;
        dlat_fix = 0;
        do_reset();
        nop();
        step(1'b1, 1'b0, '0, 1'b0, '0);
        chk("stall_capture", instr_f, mem(32'hbfc0_0004));
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, '0, 1'b0, '0);
            chk("stall_hold_instr", instr_f, mem(32'hbfc0_0004));
            chk("stall_hold_pc", pc_f, 32'hbfc0_0004);
            chk("stall_no_req", 32'(ibus.ireq_valid), 32'd0);
        end
        nop();
        chk("stall_release_dok", 32'(i_data_ok), 32'd1);
        nop();
        chk("stall_next_addr", ibus.ireq_addr, 32'hbfc0_0008);

        // redirect arriving with the delay-slot fetch (bypass path)
        do_reset();
        nop();
        nop();
        step(1'b0, 1'b1, 32'hbfc0_0100, 1'b0, '0);
        chk("redir_slot_pc", pc_f, 32'hbfc0_0008);
        chk("redir_slot_instr", instr_f, mem(32'hbfc0_0008));
        nop();
        chk("redir_target", ibus.ireq_addr, 32'hbfc0_0100);

        // redirect held pending while the slot fetch waits for data
        dlat_fix = 2;
        do_reset();
        nop();
        step(1'b0, 1'b1, 32'hbfc0_0100, 1'b0, '0);
        nop();
        chk("redir_pend_slot", pc_f, 32'hbfc0_0000);
        nop();
        chk("redir_pend_target", ibus.ireq_addr, 32'hbfc0_0100);

        // flush in WAIT discards the late response
        dlat_fix = 3;
        do_reset();
        nop();
        step(1'b0, 1'b0, '0, 1'b1, 32'hbfc0_0380);
        nop();
        nop();
        chk("flush_late_dok", 32'(ibus.iresp_data_ok), 32'd1);
        chk("flush_no_deliver", 32'(i_data_ok), 32'd0);
        nop();
        chk("flush_restart_vld", 32'(ibus.ireq_valid), 32'd1);
        chk("flush_restart_addr", ibus.ireq_addr, 32'hbfc0_0380);

        // PC wraps from the top of the address space
        dlat_fix = 0;
        do_reset();
        step(1'b0, 1'b1, 32'hffff_fffc, 1'b0, '0);
        nop();
        chk("wrap_top", ibus.ireq_addr, 32'hffff_fffc);
        nop();
        chk("wrap_zero", ibus.ireq_addr, 32'h0000_0000);

        // random latencies, stalls, redirects and flushes
        rand_lat = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic  s;
            logic  rv;
            logic  fv;
            addr_t rp;
            addr_t fp;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            fv = ($urandom_range(0, 24) == 0);
            rp = 32'hbfc0_0000 + (32'($urandom_range(0, 1023)) << 2);
            fp = 32'h8000_0180 + (32'($urandom_range(0, 255)) << 2);
            step(s, rv, rp, fv, fp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
